// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage between EX/MEM and MEM/WB.
// Runs a req/ack handshake with data memory for byte/word loads and stores
// (abandoned after TIMEOUT_CYCLES waiting cycles), resolves branch/jump
// redirects and presents one registered write-back result per instruction.
// Optional feature macro: MEM_ALIGN_CHECK_EN -- when defined, misaligned word
// accesses are rejected in one cycle with a mem_error pulse instead of being
// performed as aligned accesses.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [1:0]  in_Mem_Write_Read,
    input  logic        in_word_byte,
    input  logic [31:0] in_ALUOut,
    input  logic [31:0] in_write_data,
    input  logic        in_RegWrite,
    input  logic [1:0]  in_RegSrc,
    input  logic [4:0]  in_write_reg_dest,
    input  logic        in_ZF,
    input  logic [1:0]  in_branch_inst,
    input  logic [1:0]  in_jump,
    input  logic [31:0] in_branch_address,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_mem,
    output logic        pc_redirect,
    output logic [31:0] redirect_addr,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic [4:0]  wb_write_reg_dest,
    output logic [31:0] wb_write_data,
    output logic        mem_error
);

    // Counter only has to reach TIMEOUT_CYCLES-1; the last waiting cycle ends the access.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;

    // Fields of the instruction that owns the outstanding memory access
    logic        lat_we;
    logic        lat_word;
    logic        lat_reg_write;
    logic [1:0]  lat_reg_src;
    logic [4:0]  lat_dest;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_taken;
    logic [31:0] lat_branch_addr;

    logic        in_mem_op;
    logic        in_misaligned;
    logic        in_taken;
    logic        accept_mem;
    logic        accept_direct;
    logic        ack_hit;
    logic        timeout_hit;
    logic [7:0]  load_byte;
    logic [31:0] load_data;

    assign in_mem_op = (in_Mem_Write_Read == 2'b01) || (in_Mem_Write_Read == 2'b10);

`ifdef MEM_ALIGN_CHECK_EN
    assign in_misaligned = in_mem_op && in_word_byte && (in_ALUOut[1:0] != 2'b00);
`else
    assign in_misaligned = 1'b0;
`endif

    assign in_taken = ((in_branch_inst == 2'b01) && in_ZF)
                   || ((in_branch_inst == 2'b10) && !in_ZF)
                   || (in_jump == 2'b01);

    // Accepted instructions either start a memory access or complete directly next edge
    assign accept_mem    = (state == IDLE) && in_valid && in_mem_op && !in_misaligned;
    assign accept_direct = (state == IDLE) && in_valid && (!in_mem_op || in_misaligned);
    assign ack_hit       = (state == REQ) && dmem_ack;
    assign timeout_hit   = (state == REQ) && !dmem_ack
                        && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Upstream is frozen while an access is starting or still waiting for memory
    assign stall_mem = rst_n && (accept_mem || ((state == REQ) && !dmem_ack && !timeout_hit));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave REQ on acknowledge or when the wait budget is exhausted
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept_mem) state_next = REQ;
            REQ:  if (ack_hit || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory request outputs, driven only while an access is outstanding
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_be    = '0;
        if (state == REQ) begin
            dmem_req  = 1'b1;
            dmem_we   = lat_we;
            dmem_addr = {lat_addr[31:2], 2'b00};
            if (lat_word) begin
                dmem_be    = 4'hF;
                dmem_wdata = lat_we ? lat_wdata : '0;
            end else begin
                dmem_be    = 4'b0001 << lat_addr[1:0];
                dmem_wdata = lat_we ? {4{lat_wdata[7:0]}} : '0;
            end
        end
    end

    // Little-endian byte lane selection for byte loads, zero-extended
    always_comb begin
        load_byte = dmem_rdata[7:0];
        case (lat_addr[1:0])
            2'b01:   load_byte = dmem_rdata[15:8];
            2'b10:   load_byte = dmem_rdata[23:16];
            2'b11:   load_byte = dmem_rdata[31:24];
            default: load_byte = dmem_rdata[7:0];
        endcase
        load_data = lat_word ? dmem_rdata : {24'h0, load_byte};
    end

    // Wait counter, instruction latch and registered write-back/redirect results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt          <= '0;
            lat_we            <= 1'b0;
            lat_word          <= 1'b0;
            lat_reg_write     <= 1'b0;
            lat_reg_src       <= '0;
            lat_dest          <= '0;
            lat_addr          <= '0;
            lat_wdata         <= '0;
            lat_taken         <= 1'b0;
            lat_branch_addr   <= '0;
            wb_valid          <= 1'b0;
            wb_RegWrite       <= 1'b0;
            wb_write_reg_dest <= '0;
            wb_write_data     <= '0;
            pc_redirect       <= 1'b0;
            redirect_addr     <= '0;
            mem_error         <= 1'b0;
        end else begin
            wb_valid      <= 1'b0;
            pc_redirect   <= 1'b0;
            redirect_addr <= '0;
            mem_error     <= 1'b0;

            if (accept_mem) begin
                wait_cnt        <= '0;
                lat_we          <= (in_Mem_Write_Read == 2'b10);
                lat_word        <= in_word_byte;
                lat_reg_write   <= in_RegWrite;
                lat_reg_src     <= in_RegSrc;
                lat_dest        <= in_write_reg_dest;
                lat_addr        <= in_ALUOut;
                lat_wdata       <= in_write_data;
                lat_taken       <= in_taken;
                lat_branch_addr <= in_branch_address;
            end else if ((state == REQ) && !dmem_ack && !timeout_hit) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            if (accept_direct) begin
                wb_valid          <= 1'b1;
                wb_RegWrite       <= in_RegWrite && !in_misaligned;
                wb_write_reg_dest <= in_write_reg_dest;
                wb_write_data     <= in_ALUOut;
                mem_error         <= in_misaligned;
                pc_redirect       <= in_taken;
                redirect_addr     <= in_taken ? in_branch_address : '0;
            end else if (ack_hit) begin
                wb_valid          <= 1'b1;
                wb_RegWrite       <= lat_reg_write && !lat_we;
                wb_write_reg_dest <= lat_dest;
                wb_write_data     <= (!lat_we && (lat_reg_src == 2'b01)) ? load_data : lat_addr;
                pc_redirect       <= lat_taken;
                redirect_addr     <= lat_taken ? lat_branch_addr : '0;
            end else if (timeout_hit) begin
                wb_valid          <= 1'b1;
                wb_RegWrite       <= 1'b0;
                wb_write_reg_dest <= lat_dest;
                wb_write_data     <= lat_addr;
                mem_error         <= 1'b1;
                pc_redirect       <= lat_taken;
                redirect_addr     <= lat_taken ? lat_branch_addr : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: self-checking bench for mem_access_stage.
// Directed vector table, hand-written multi-cycle sequences (reset, idle ack,
// pulse widths) and randomized instructions against a reference model.
module tb_mem_access_stage;

    localparam int TIMEOUT_CYCLES = 16;
    localparam int NEVER          = 1000;
    localparam int NV             = 13;
    localparam int NRAND          = 80;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  in_Mem_Write_Read;
    logic        in_word_byte;
    logic [31:0] in_ALUOut;
    logic [31:0] in_write_data;
    logic        in_RegWrite;
    logic [1:0]  in_RegSrc;
    logic [4:0]  in_write_reg_dest;
    logic        in_ZF;
    logic [1:0]  in_branch_inst;
    logic [1:0]  in_jump;
    logic [31:0] in_branch_address;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_mem;
    logic        pc_redirect;
    logic [31:0] redirect_addr;
    logic        wb_valid;
    logic        wb_RegWrite;
    logic [4:0]  wb_write_reg_dest;
    logic [31:0] wb_write_data;
    logic        mem_error;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_Mem_Write_Read (in_Mem_Write_Read),
        .in_word_byte      (in_word_byte),
        .in_ALUOut         (in_ALUOut),
        .in_write_data     (in_write_data),
        .in_RegWrite       (in_RegWrite),
        .in_RegSrc         (in_RegSrc),
        .in_write_reg_dest (in_write_reg_dest),
        .in_ZF             (in_ZF),
        .in_branch_inst    (in_branch_inst),
        .in_jump           (in_jump),
        .in_branch_address (in_branch_address),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_be           (dmem_be),
        .dmem_ack          (dmem_ack),
        .dmem_rdata        (dmem_rdata),
        .stall_mem         (stall_mem),
        .pc_redirect       (pc_redirect),
        .redirect_addr     (redirect_addr),
        .wb_valid          (wb_valid),
        .wb_RegWrite       (wb_RegWrite),
        .wb_write_reg_dest (wb_write_reg_dest),
        .wb_write_data     (wb_write_data),
        .mem_error         (mem_error)
    );

    // Free-running clock
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mwr;
        logic        word;
        logic [31:0] alu;
        logic [31:0] wd;
        logic        rw;
        logic [1:0]  src;
        logic [4:0]  dest;
        logic        zf;
        logic [1:0]  br;
        logic [1:0]  jmp;
        logic [31:0] baddr;
    } instr_t;

    typedef struct {
        int          lat;
        int          stall;
        int          req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        rw;
        logic [4:0]  dest;
        logic [31:0] data;
        logic        err;
        logic        redir;
        logic [31:0] raddr;
        logic        chk_data;
        logic        chk_wdata;
    } obs_t;

    typedef struct {
        instr_t      ins;
        int          ack_wait;
        logic [31:0] rdata;
        obs_t        exp;
    } vec_t;

    vec_t vecs [NV];

    function automatic instr_t mkIns(input logic [1:0] mwr, input logic word, input logic [31:0] alu,
                                     input logic [31:0] wd, input logic rw, input logic [1:0] src,
                                     input logic [4:0] dest, input logic zf, input logic [1:0] br,
                                     input logic [1:0] jmp, input logic [31:0] baddr);
        instr_t r;
        r = '{mwr, word, alu, wd, rw, src, dest, zf, br, jmp, baddr};
        return r;
    endfunction

    function automatic obs_t mkExp(input int lat, input int stall, input int req, input logic we,
                                   input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                                   input logic rw, input logic [4:0] dest, input logic [31:0] data,
                                   input logic err, input logic redir, input logic [31:0] raddr,
                                   input logic chk_data, input logic chk_wdata);
        obs_t r;
        r = '{lat, stall, req, we, addr, wdata, be, rw, dest, data, err, redir, raddr, chk_data, chk_wdata};
        return r;
    endfunction

    // Reference model: expected observations of one instruction from the stage's rules
    function automatic obs_t refModel(input instr_t ins, input int ack_wait, input logic [31:0] rdata);
        obs_t        e;
        bit          is_rd;
        bit          is_wr;
        bit          misal;
        bit          taken;
        bit          tmo;
        logic [31:0] lane;
        logic [31:0] loaded;
        e     = '{default: 0};
        is_rd = (ins.mwr == 2'b01);
        is_wr = (ins.mwr == 2'b10);
        misal = 0;
`ifdef MEM_ALIGN_CHECK_EN
        misal = (is_rd || is_wr) && ins.word && ((ins.alu % 4) != 0);
`endif
        taken = (ins.br == 2'b01 && ins.zf) || (ins.br == 2'b10 && !ins.zf) || (ins.jmp == 2'b01);
        e.redir    = taken;
        e.raddr    = taken ? ins.baddr : 32'h0;
        e.dest     = ins.dest;
        e.chk_data = 1;
        if (!(is_rd || is_wr)) begin
            e.lat  = 1;
            e.rw   = ins.rw;
            e.data = ins.alu;
        end else if (misal) begin
            e.lat      = 1;
            e.err      = 1;
            e.rw       = 0;
            e.chk_data = 0;
        end else begin
            tmo         = (ack_wait >= TIMEOUT_CYCLES);
            e.req       = tmo ? TIMEOUT_CYCLES : ack_wait + 1;
            e.stall     = tmo ? TIMEOUT_CYCLES : ack_wait + 1;
            e.lat       = tmo ? TIMEOUT_CYCLES + 1 : ack_wait + 2;
            e.we        = is_wr;
            e.addr      = ins.alu - (ins.alu % 4);
            e.be        = ins.word ? 4'hF : 4'(1 << (ins.alu % 4));
            e.wdata     = ins.word ? ins.wd : ({24'h0, ins.wd[7:0]} * 32'h01010101);
            e.chk_wdata = is_wr;
            e.err       = tmo;
            e.rw        = !tmo && is_rd && ins.rw;
            lane        = (rdata >> (8 * (ins.alu % 4))) & 32'hFF;
            loaded      = ins.word ? rdata : lane;
            e.data      = (is_rd && ins.src == 2'b01) ? loaded : ins.alu;
            e.chk_data  = !tmo;
        end
        return e;
    endfunction

    function automatic logic [143:0] allOutputs();
        return {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, stall_mem, pc_redirect,
                redirect_addr, wb_valid, wb_RegWrite, wb_write_reg_dest, wb_write_data, mem_error};
    endfunction

    task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic driveFields(input instr_t ins);
        in_Mem_Write_Read = ins.mwr;
        in_word_byte      = ins.word;
        in_ALUOut         = ins.alu;
        in_write_data     = ins.wd;
        in_RegWrite       = ins.rw;
        in_RegSrc         = ins.src;
        in_write_reg_dest = ins.dest;
        in_ZF             = ins.zf;
        in_branch_inst    = ins.br;
        in_jump           = ins.jmp;
        in_branch_address = ins.baddr;
    endtask

    // Present one instruction, act as upstream and memory, record what the stage did
    task automatic applyStimulus(input instr_t ins, input int ack_wait, input logic [31:0] rdata,
                                 output obs_t o);
        int   cyc;
        logic done;
        logic stall_now;
        logic ack_now;
        o = '{default: 0};
        driveFields(ins);
        in_valid = 1'b1;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            ack_now = 1'b0;
            if (dmem_req) begin
                if (o.req == 0) begin
                    o.we    = dmem_we;
                    o.addr  = dmem_addr;
                    o.wdata = dmem_wdata;
                    o.be    = dmem_be;
                end
                ack_now = (o.req == ack_wait);
                o.req++;
            end
            dmem_ack   = ack_now;
            dmem_rdata = ack_now ? rdata : $urandom;
            #1;
            stall_now = stall_mem;
            if (stall_now) o.stall++;
            @(posedge clk);
            #1;
            cyc++;
            dmem_ack = 1'b0;
            if (!stall_now) in_valid = 1'b0;
            if (wb_valid) begin
                o.lat   = cyc;
                o.rw    = wb_RegWrite;
                o.dest  = wb_write_reg_dest;
                o.data  = wb_write_data;
                o.err   = mem_error;
                o.redir = pc_redirect;
                o.raddr = redirect_addr;
                done    = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) checkOutput("wb_valid_within_bound", 0, 1);
    endtask

    task automatic compareObs(input string tag, input obs_t a, input obs_t e);
        checkOutput({tag, "_latency"}, a.lat, e.lat);
        checkOutput({tag, "_stall_cycles"}, a.stall, e.stall);
        checkOutput({tag, "_req_cycles"}, a.req, e.req);
        checkOutput({tag, "_wb_RegWrite"}, a.rw, e.rw);
        checkOutput({tag, "_mem_error"}, a.err, e.err);
        checkOutput({tag, "_pc_redirect"}, a.redir, e.redir);
        checkOutput({tag, "_redirect_addr"}, a.raddr, e.raddr);
        if (e.chk_data) begin
            checkOutput({tag, "_wb_dest"}, a.dest, e.dest);
            checkOutput({tag, "_wb_data"}, a.data, e.data);
        end
        if (e.req > 0) begin
            checkOutput({tag, "_dmem_addr"}, a.addr, e.addr);
            checkOutput({tag, "_dmem_be"}, a.be, e.be);
            checkOutput({tag, "_dmem_we"}, a.we, e.we);
        end
        if (e.chk_wdata) checkOutput({tag, "_dmem_wdata"}, a.wdata, e.wdata);
    endtask

    // Main test sequence
    initial begin
        obs_t   o;
        instr_t ins;
        int     aw;
        int     gap;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        driveFields(mkIns(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Directed vectors: instr, ack wait cycles, read data, expected observations
        vecs[0]  = '{mkIns(2'b00, 1, 32'h1234, 0, 1, 0, 5, 0, 0, 0, 0), 0, 32'h0,
                     mkExp(1, 0, 0, 0, 0, 0, 0, 1, 5, 32'h1234, 0, 0, 0, 1, 0)};
        vecs[1]  = '{mkIns(2'b01, 1, 32'h100, 0, 1, 1, 7, 0, 0, 0, 0), 3, 32'hDEADBEEF,
                     mkExp(5, 4, 4, 0, 32'h100, 0, 4'hF, 1, 7, 32'hDEADBEEF, 0, 0, 0, 1, 0)};
        vecs[2]  = '{mkIns(2'b10, 0, 32'h203, 32'h000000A5, 1, 0, 3, 0, 0, 0, 0), 0, 32'h0,
                     mkExp(2, 1, 1, 1, 32'h200, 32'hA5A5A5A5, 4'b1000, 0, 3, 32'h203, 0, 0, 0, 1, 1)};
        vecs[3]  = '{mkIns(2'b01, 0, 32'h202, 0, 1, 1, 9, 0, 0, 0, 0), 1, 32'h11223344,
                     mkExp(3, 2, 2, 0, 32'h200, 0, 4'b0100, 1, 9, 32'h00000022, 0, 0, 0, 1, 0)};
        vecs[4]  = '{mkIns(2'b00, 1, 32'h99, 0, 0, 0, 0, 0, 2'b10, 0, 32'h40), 0, 32'h0,
                     mkExp(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h99, 0, 1, 32'h40, 1, 0)};
        vecs[5]  = '{mkIns(2'b00, 1, 32'h55, 0, 0, 0, 1, 0, 2'b01, 0, 32'h80), 0, 32'h0,
                     mkExp(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55, 0, 0, 0, 1, 0)};
        vecs[6]  = '{mkIns(2'b00, 1, 32'h0, 0, 1, 0, 31, 1, 0, 2'b01, 32'h1000), 0, 32'h0,
                     mkExp(1, 0, 0, 0, 0, 0, 0, 1, 31, 32'h0, 0, 1, 32'h1000, 1, 0)};
        vecs[7]  = '{mkIns(2'b11, 1, 32'h300, 0, 1, 1, 4, 0, 0, 0, 0), 0, 32'h0,
                     mkExp(1, 0, 0, 0, 0, 0, 0, 1, 4, 32'h300, 0, 0, 0, 1, 0)};
        vecs[8]  = '{mkIns(2'b10, 1, 32'h400, 32'h12345678, 0, 0, 2, 0, 0, 0, 0), NEVER, 32'h0,
                     mkExp(17, 16, 16, 1, 32'h400, 32'h12345678, 4'hF, 0, 2, 0, 1, 0, 0, 0, 1)};
        vecs[9]  = '{mkIns(2'b01, 1, 32'h500, 0, 1, 1, 10, 0, 0, 0, 0), 15, 32'hCAFEF00D,
                     mkExp(17, 16, 16, 0, 32'h500, 0, 4'hF, 1, 10, 32'hCAFEF00D, 0, 0, 0, 1, 0)};
`ifdef MEM_ALIGN_CHECK_EN
        vecs[10] = '{mkIns(2'b01, 1, 32'h102, 0, 1, 1, 12, 0, 0, 0, 0), 0, 32'hA1B2C3D4,
                     mkExp(1, 0, 0, 0, 0, 0, 0, 0, 12, 0, 1, 0, 0, 0, 0)};
`else
        vecs[10] = '{mkIns(2'b01, 1, 32'h102, 0, 1, 1, 12, 0, 0, 0, 0), 0, 32'hA1B2C3D4,
                     mkExp(2, 1, 1, 0, 32'h100, 0, 4'hF, 1, 12, 32'hA1B2C3D4, 0, 0, 0, 1, 0)};
`endif
        vecs[11] = '{mkIns(2'b01, 0, 32'h0FF, 0, 1, 1, 13, 0, 0, 0, 0), 0, 32'h80FFFFFF,
                     mkExp(2, 1, 1, 0, 32'hFC, 0, 4'b1000, 1, 13, 32'h00000080, 0, 0, 0, 1, 0)};
        vecs[12] = '{mkIns(2'b01, 1, 32'h10, 0, 1, 0, 14, 0, 0, 0, 0), 2, 32'h77777777,
                     mkExp(4, 3, 3, 0, 32'h10, 0, 4'hF, 1, 14, 32'h10, 0, 0, 0, 1, 0)};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", allOutputs(), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_idle_outputs", allOutputs(), 0);

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].ins, vecs[i].ack_wait, vecs[i].rdata, o);
            compareObs($sformatf("vec%0d", i), o, vecs[i].exp);
        end

        // wb data holds after the single-cycle valid/redirect pulse
        ins = mkIns(2'b00, 1, 32'hABCD0123, 0, 1, 0, 17, 0, 0, 2'b01, 32'h2000);
        applyStimulus(ins, 0, 32'h0, o);
        compareObs("hold", o, refModel(ins, 0, 32'h0));
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput("hold_pulses_low", {wb_valid, pc_redirect, mem_error}, 0);
            checkOutput("hold_wb_fields", {wb_RegWrite, wb_write_reg_dest, wb_write_data},
                        {1'b1, 5'd17, 32'hABCD0123});
        end

        // Timeout error is a single-cycle pulse and the request is gone afterwards
        ins = mkIns(2'b01, 0, 32'h701, 0, 1, 1, 6, 0, 0, 0, 0);
        applyStimulus(ins, NEVER, 32'h0, o);
        compareObs("tmo", o, refModel(ins, NEVER, 32'h0));
        @(posedge clk);
        #1;
        checkOutput("tmo_pulse_single", {mem_error, wb_valid, dmem_req}, 0);

        // Acknowledge while idle has no effect
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5A5A5A5A;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("idle_ack_ignored", {wb_valid, dmem_req, stall_mem, mem_error}, 0);
        end
        dmem_ack = 1'b0;

        // Reset in the middle of an access abandons it; a late ack is ignored
        driveFields(mkIns(2'b01, 1, 32'h600, 0, 1, 1, 8, 0, 0, 0, 0));
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("midreq_req_active", dmem_req, 1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midreq_reset_outputs", allOutputs(), 0);
        rst_n      = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFFFFFF;
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput("late_ack_no_wb", {wb_valid, dmem_req, mem_error}, 0);
        end
        dmem_ack = 1'b0;

        // Randomized instructions against the reference model
        for (int k = 0; k < NRAND; k++) begin
            ins = mkIns(2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom, 1'($urandom),
                        2'($urandom_range(0, 3)), 5'($urandom), 1'($urandom),
                        2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
            aw = ($urandom_range(0, 14) == 0) ? NEVER : int'($urandom_range(0, 5));
            dmem_rdata = $urandom;
            applyStimulus(ins, aw, dmem_rdata, o);
            compareObs($sformatf("rand%0d", k), o, refModel(ins, aw, dmem_rdata));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
                checkOutput("gap_no_wb", {wb_valid, dmem_req}, 0);
            end
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage sitting directly downstream of the EX/MEM pipeline register and upstream of MEM/WB. It consumes the registered EX results and control fields, runs a req/ack handshake with data memory for loads and stores (byte and word), resolves branch/jump redirects, and presents one registered write-back result per instruction. While a memory transaction is outstanding it stalls the upstream stages.

## Interface
- TIMEOUT_CYCLES, 16: maximum REQ-state cycles without `dmem_ack` before the access is abandoned (≥1).
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  EX/MEM holds a valid instruction.
- in_Mem_Write_Read  in  2  00 none, 01 read, 10 write, 11 treated as none.
- in_word_byte  in  1  1 word, 0 byte.
- in_ALUOut  in  32  effective address / ALU result.
- in_write_data  in  32  store data.
- in_RegWrite  in  1  instruction writes the register file.
- in_RegSrc  in  2  00 ALU result, 01 load data, others ALU result.
- in_write_reg_dest  in  5  destination register.
- in_ZF, in_branch_inst (2), in_jump (2), in_branch_address (32)  in  branch resolution: branch_inst 01 taken if ZF=1, 10 taken if ZF=0; jump 01 always taken.
- dmem_req  out  1  request valid; dmem_we  out  1  write; dmem_addr  out  32  {addr[31:2],2'b00}; dmem_wdata  out  32; dmem_be  out  4  byte enables.
- dmem_ack  in  1  completes current request; dmem_rdata  in  32  valid with ack.
- stall_mem  out  1  freeze EX/MEM and earlier stages.
- pc_redirect  out  1; redirect_addr  out  32.
- wb_valid, wb_RegWrite  out  1; wb_write_reg_dest  out  5; wb_write_data  out  32.
- mem_error  out  1  one-cycle pulse on timeout or (if enabled) misalignment.

## Operation
- FSM: IDLE, REQ. Accepted instruction fields latched internally on acceptance.
- IDLE, in_valid, no memory op: result registered to wb_* next edge; wb_write_data = in_ALUOut; redirect evaluated and registered alongside.
- IDLE, in_valid, read/write: latch fields, go REQ; counter cleared.
- REQ: dmem_req=1 with latched address/data. On dmem_ack: register wb outputs, return IDLE. Load data: word = dmem_rdata; byte = zero-extended lane addr[1:0] (little-endian). Stores: wb_RegWrite forced 0.
- Byte store: dmem_wdata = {4{data[7:0]}}, dmem_be = 4'b0001 << addr[1:0]. Word: wdata = data, be = 4'hF.
- Timeout: counter increments each REQ cycle without ack; reaching TIMEOUT_CYCLES drops req, pulses mem_error, emits wb_valid=1 with wb_RegWrite=0, returns IDLE.
- stall_mem = (IDLE & in_valid & memop) | (REQ & ~dmem_ack & ~timeout).
- dmem_ack in IDLE ignored.
- pc_redirect/redirect_addr: one-cycle registered pulse with the instruction's wb_valid; redirect_addr = in_branch_address when taken, else 0.

## Timing
- Non-memory latency: 1 cycle (input at edge N, wb_valid after edge N+1).
- Memory latency: 2 + wait cycles; ack in first REQ cycle → wb_valid 2 cycles after acceptance.
- wb_valid, pc_redirect, mem_error are single-cycle pulses; wb_* data hold until next result.
- Reset: state IDLE, counter 0, every output 0. Reset during REQ: dmem_req low next cycle, transaction abandoned, no wb_valid, late ack ignored.
- Simultaneous ack and timeout count reached: ack wins, no mem_error.

## Configuration
- MEM_ALIGN_CHECK_EN defined: word access with addr[1:0]≠0 issues no request, completes in 1 cycle with mem_error pulse, wb_valid=1, wb_RegWrite=0, stall_mem=0.
- Undefined: addr[1:0] ignored for word accesses; aligned access performed, no error.

## Test plan
- ALU op addr 0x1234, RegWrite=1, dest 5 → wb_valid one cycle later, wb_write_data=0x1234, dest 5, stall_mem never high.
- Word load 0x100, ack after 3 REQ cycles, rdata 0xDEADBEEF → dmem_addr 0x100, be F, stall high 4 cycles, wb_write_data 0xDEADBEEF.
- Byte store 0x203 data 0x000000A5 → be 4'b1000, wdata 0xA5A5A5A5, we=1, wb_RegWrite=0.
- Byte load 0x202, rdata 0x11223344 → wb_write_data 0x00000022.
- No ack, TIMEOUT_CYCLES=16 → req high 16 cycles then drops, mem_error pulse, wb_RegWrite=0; rst_n low mid-REQ → all outputs 0 next cycle.
- branch_inst 10, ZF=0, addr 0x40 → pc_redirect pulse, redirect_addr 0x40; with MEM_ALIGN_CHECK_EN, word load 0x102 → mem_error, no dmem_req.
